// File: rtl/ov7670_cfg_seq.sv
// rtl/ov7670_cfg_seq.sv - OV7670 power-up register sequencer over SCCB
// Walks a {reg,val} ROM, issuing one SCCB write per entry with delay entries and NACK retries.
module ov7670_cfg_seq #(
  parameter int          ADDR_W       = 8,
  parameter int          DELAY_CYCLES = 1000000,
  parameter int          MAX_RETRY    = 3,
  parameter logic [15:0] END_WORD     = 16'hFFFF,
  parameter logic [15:0] DELAY_WORD   = 16'hFFF0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [15:0]       cmd_data,
  input  logic              xfer_done,
  input  logic              xfer_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int DLY_W   = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES + 1) : 1;

  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [DLY_W-1:0]   DELAY_LOAD  = DLY_W'(DELAY_CYCLES - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR   = {ADDR_W{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_XFER, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [15:0]         cmd_data_q, cmd_data_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [DLY_W-1:0]    delay_q, delay_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      cmd_data_q <= '0;
      retry_q    <= '0;
      delay_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      cmd_data_q <= cmd_data_d;
      retry_q    <= retry_d;
      delay_q    <= delay_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    cmd_data_d = cmd_data_q;
    retry_d    = retry_q;
    delay_d    = delay_q;
    done_d     = done_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          rom_addr_d = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data == END_WORD) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (rom_data == DELAY_WORD) begin
          state_d = S_DELAY;
          delay_d = DELAY_LOAD;
        end else begin
          state_d    = S_ISSUE;
          cmd_data_d = rom_data;
          retry_d    = '0;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) state_d = S_WAIT_XFER;
      end
      // Only completions seen here count; a pulse coincident with acceptance is dropped.
      S_WAIT_XFER: begin
        if (xfer_done) begin
          if (!xfer_nack) begin
            state_d = S_NEXT;
          end else if (retry_q < RETRY_LIMIT) begin
            state_d = S_ISSUE;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            err_addr_d = rom_addr_q;
          end
        end
      end
      S_DELAY: begin
        if (delay_q == '0) state_d = S_NEXT;
        else               delay_d = delay_q - 1'b1;
      end
      S_NEXT: begin
        if (rom_addr_q == LAST_ADDR) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = S_FETCH;
          rom_addr_d = rom_addr_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr  = rom_addr_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_valid = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done      = done_q;
  assign error     = error_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// tb/tb_ov7670_cfg_seq.sv - randomized self-checking bench for ov7670_cfg_seq
module tb_ov7670_cfg_seq;
  localparam int          AW    = 8;
  localparam int          DLY   = 20;
  localparam int          MAXR  = 3;
  localparam logic [15:0] END_W = 16'hFFFF;
  localparam logic [15:0] DLY_W = 16'hFFF0;

  typedef struct packed { logic [15:0] w; logic [7:0] a; logic [15:0] gap; } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, cmd_valid, cmd_ready, xfer_done, xfer_nack, busy, done, error;
  logic [AW-1:0] rom_addr, err_addr;
  logic [15:0]   rom_data, cmd_data;
  logic [15:0]   rom [0:255];

  logic        start2, cmd2_valid, cmd2_ready, xfer2_done, xfer2_nack, busy2, done2, error2;
  logic [1:0]  rom2_addr, err2_addr;
  logic [15:0] rom2_data, cmd2_data;
  logic [15:0] rom2 [0:3];

  int vectors = 0, miscompares = 0, cyc = 0;

  ov7670_cfg_seq #(.ADDR_W(AW), .DELAY_CYCLES(DLY), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .xfer_done(xfer_done),
    .xfer_nack(xfer_nack), .busy(busy), .done(done), .error(error), .err_addr(err_addr));

  ov7670_cfg_seq #(.ADDR_W(2), .DELAY_CYCLES(4), .MAX_RETRY(MAXR)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .rom_addr(rom2_addr), .rom_data(rom2_data),
    .cmd_valid(cmd2_valid), .cmd_ready(cmd2_ready), .cmd_data(cmd2_data), .xfer_done(xfer2_done),
    .xfer_nack(xfer2_nack), .busy(busy2), .done(done2), .error(error2), .err_addr(err2_addr));

  always @(posedge clk) rom_data  <= rom[rom_addr];
  always @(posedge clk) rom2_data <= rom2[rom2_addr];

  // SCCB master model / monitor settings and logs
  int   ready_wait_cfg, lat_lo, lat_hi, rdy_wait, last_evt, proto_err;
  bit   stray_en;
  bit   nack_sched[$];
  bit   nack_plan[$];
  txn_t act_q[$];
  txn_t exp_q[$];
  logic [15:0] log2[$];
  bit          exp_done, exp_err;
  logic [7:0]  exp_err_addr;

  initial begin : sccb_model
    int xfer_cnt;
    bit cur_nack, prev_valid, acc_armed;
    logic [15:0] held_w, held_gap;
    logic [7:0]  held_a;
    xfer_cnt = 0; cur_nack = 0; prev_valid = 0; acc_armed = 0;
    held_w = '0; held_gap = '0; held_a = '0;
    cmd_ready = 0; xfer_done = 0; xfer_nack = 0;
    forever begin
      @(negedge clk);
      cyc++;
      xfer_done = 0;
      xfer_nack = 0;
      if (!reset_n) begin
        cmd_ready = 0; xfer_cnt = 0; prev_valid = 0; acc_armed = 0;
      end else begin
        if (acc_armed) begin
          act_q.push_back(txn_t'({held_w, held_a, held_gap}));
          cmd_ready = 0;
          acc_armed = 0;
          if (cmd_valid) proto_err++;
          xfer_cnt = $urandom_range(lat_hi, lat_lo);
          cur_nack = (nack_sched.size() > 0) ? nack_sched.pop_front() : 1'b0;
          rdy_wait = (ready_wait_cfg < 0) ? $urandom_range(3, 0) : ready_wait_cfg;
        end else if (xfer_cnt > 0) begin
          if (cmd_valid) proto_err++;
          xfer_cnt--;
          if (xfer_cnt == 0) begin
            xfer_done = 1;
            xfer_nack = cur_nack;
            last_evt  = cyc;
          end
        end else if (cmd_valid) begin
          if (!prev_valid) begin
            held_w = cmd_data; held_a = rom_addr; held_gap = 16'(cyc - last_evt);
          end else if (cmd_data !== held_w) begin
            proto_err++;
          end
          if (rdy_wait == 0) begin
            cmd_ready = 1;
            acc_armed = 1;
            if (stray_en) xfer_done = 1;
          end else begin
            rdy_wait--;
          end
        end
        prev_valid = cmd_valid;
      end
    end
  end

  initial begin : sccb_model2
    int cnt;
    cnt = 0; xfer2_done = 0; xfer2_nack = 0; cmd2_ready = 1;
    forever begin
      @(negedge clk);
      xfer2_done = 0;
      if (!reset_n) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) xfer2_done = 1;
      end else if (cmd2_valid) begin
        log2.push_back(cmd2_data);
        cnt = 3;
      end
    end
  end

  function automatic logic [15:0] rnd_word();
    return 16'($urandom_range(16'hFFEF, 0));
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = END_W;
  endtask

  // Expected write list, gaps and outcome, derived from the ROM walk rules.
  task automatic build_model();
    int addr, extra, k, tries;
    bit fin, nk;
    logic [15:0] w;
    exp_q.delete(); exp_done = 0; exp_err = 0; exp_err_addr = '0;
    addr = 0; extra = 3; k = 0; fin = 0;
    while (!fin) begin
      w = rom[addr];
      if (w == END_W) begin
        exp_done = 1; fin = 1;
      end else begin
        if (w == DLY_W) extra += DLY + 3;
        else begin
          tries = 0;
          do begin
            exp_q.push_back(txn_t'({w, 8'(addr), 16'(extra)}));
            nk = (k < nack_plan.size()) ? nack_plan[k] : 1'b0;
            k++;
            if (nk && tries == MAXR) begin
              exp_err = 1; exp_err_addr = 8'(addr); fin = 1;
            end else if (nk) begin
              tries++; extra = 1;
            end else begin
              extra = 4;
            end
          end while (nk && !fin);
        end
        if (!fin) begin
          if (addr == 255) begin exp_done = 1; fin = 1; end
          else addr++;
        end
      end
    end
  endtask

  task automatic run_seq(input int budget, input int restart_at, input bit start_in_done,
                         output bit to, output int fall_gap);
    act_q.delete();
    proto_err = 0;
    nack_sched = nack_plan;
    build_model();
    rdy_wait = (ready_wait_cfg < 0) ? $urandom_range(3, 0) : ready_wait_cfg;
    @(negedge clk); #2;
    start = 1; last_evt = cyc;
    @(negedge clk); #2;
    start = 0;
    to = 1; fall_gap = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!busy) begin to = 0; fall_gap = cyc - last_evt; break; end
      if (i == restart_at) begin
        #1 start = 1;
        @(negedge clk); #2 start = 0;
      end
    end
    if (start_in_done && !to) begin
      start = 1;
      @(negedge clk); #2 start = 0;
    end
    repeat (20) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({rom_addr, cmd_valid, cmd_data, busy, done, error, err_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", {rom_addr, cmd_valid, cmd_data, busy, done, error, err_addr});
    end
    vectors++;
    if ({rom2_addr, cmd2_valid, cmd2_data, busy2, done2, error2, err2_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_state2: got %h want 0", {rom2_addr, cmd2_valid, cmd2_data, busy2, done2, error2, err2_addr});
    end
    #2 reset_n = 1;
  endtask

  task automatic test_delay_seq();
    bit to; int fg;
    rom_clear();
    rom[0] = 16'h1280; rom[1] = DLY_W; rom[2] = 16'h13E5; rom[3] = END_W;
    nack_plan.delete(); ready_wait_cfg = 0; lat_lo = 10; lat_hi = 10; stray_en = 0;
    run_seq(2000, -1, 0, to, fg);
    vectors++;
    if (to || act_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL delay_seq count: got %0d (timeout %0d) want %0d", act_q.size(), to, exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL delay_seq txn%0d: got %h want %h", i, act_q[i], exp_q[i]);
      end
    end
    vectors++;
    if ({done, error, busy} !== 3'b100 || proto_err != 0 || fg != 4) begin
      miscompares++;
      $display("FAIL delay_seq status: got done=%b err=%b busy=%b proto=%0d fall=%0d want 1 0 0 0 4",
               done, error, busy, proto_err, fg);
    end
  endtask

  task automatic test_nack_retry();
    bit to; int fg;
    rom_clear();
    rom[0] = 16'h3A04;
    nack_plan = '{1'b1, 1'b0}; ready_wait_cfg = 0; lat_lo = 3; lat_hi = 3; stray_en = 1;
    run_seq(500, -1, 0, to, fg);
    vectors++;
    if (to || act_q.size() != 2 || exp_q.size() != 2) begin
      miscompares++;
      $display("FAIL nack_retry count: got %0d (timeout %0d) want 2", act_q.size(), to);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL nack_retry txn%0d: got %h want %h", i, act_q[i], exp_q[i]);
      end
    end
    vectors++;
    if ({done, error} !== 2'b10 || proto_err != 0) begin
      miscompares++;
      $display("FAIL nack_retry status: got done=%b err=%b proto=%0d want 1 0 0", done, error, proto_err);
    end
  endtask

  task automatic test_error();
    bit to; int fg;
    rom_clear();
    for (int i = 0; i < 6; i++) rom[i] = rnd_word();
    nack_plan = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    ready_wait_cfg = -1; lat_lo = 1; lat_hi = 6; stray_en = 0;
    run_seq(2000, -1, 0, to, fg);
    vectors++;
    if (to || act_q.size() != exp_q.size() || exp_q.size() != 9) begin
      miscompares++;
      $display("FAIL error count: got %0d (timeout %0d) want %0d", act_q.size(), to, exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL error txn%0d: got %h want %h", i, act_q[i], exp_q[i]);
      end
    end
    vectors++;
    if ({done, error, busy, err_addr} !== {1'b0, 1'b1, 1'b0, 8'd5} || proto_err != 0) begin
      miscompares++;
      $display("FAIL error status: got done=%b err=%b busy=%b err_addr=%0d proto=%0d want 0 1 0 5 0",
               done, error, busy, err_addr, proto_err);
    end
  endtask

  task automatic test_ready_stall();
    bit to; int fg;
    rom_clear();
    rom[0] = 16'h1204; rom[1] = 16'h8C00;
    nack_plan.delete(); ready_wait_cfg = 50; lat_lo = 2; lat_hi = 2; stray_en = 0;
    run_seq(1000, -1, 0, to, fg);
    vectors++;
    if (to || act_q.size() != 2 || proto_err != 0) begin
      miscompares++;
      $display("FAIL ready_stall: got %0d txns proto=%0d (timeout %0d) want 2 0", act_q.size(), proto_err, to);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ready_stall txn%0d: got %h want %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to; int fg;
    rom_clear();
    for (int i = 0; i < 5; i++) rom[i] = rnd_word();
    nack_plan.delete(); ready_wait_cfg = 0; lat_lo = 6; lat_hi = 6; stray_en = 0;
    run_seq(1000, 3, 1, to, fg);
    vectors++;
    if (to || act_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL back_to_back count: got %0d (timeout %0d) want %0d", act_q.size(), to, exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL back_to_back txn%0d: got %h want %h", i, act_q[i], exp_q[i]);
      end
    end
    vectors++;
    if ({done, error, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL back_to_back status: got done=%b err=%b busy=%b want 1 0 0", done, error, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit to; int fg;
    rom_clear();
    rom[0] = 16'h1280; rom[1] = 16'h3A04; rom[2] = 16'h13E5;
    nack_plan.delete(); ready_wait_cfg = 0; lat_lo = 40; lat_hi = 40; stray_en = 0;
    act_q.delete();
    rdy_wait = 0;
    @(negedge clk); #2 start = 1;
    @(negedge clk); #2 start = 0;
    to = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (act_q.size() >= 2) begin to = 0; break; end
    end
    #1 reset_n = 0;
    #1;
    vectors++;
    if (to || {rom_addr, cmd_valid, cmd_data, busy, done, error, err_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid async: got %h (timeout %0d) want 0",
               {rom_addr, cmd_valid, cmd_data, busy, done, error, err_addr}, to);
    end
    repeat (3) @(negedge clk);
    #2 reset_n = 1;
    act_q.delete();
    repeat (20) @(negedge clk);
    #1;
    vectors++;
    if (act_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid idle: got %0d cmds busy=%b want 0 0", act_q.size(), busy);
    end
    lat_lo = 2; lat_hi = 5;
    run_seq(1000, -1, 0, to, fg);
    vectors++;
    if (to || act_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL reset_mid restart count: got %0d (timeout %0d) want %0d", act_q.size(), to, exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset_mid restart txn%0d: got %h want %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit to;
    for (int i = 0; i < 4; i++) rom2[i] = rnd_word();
    log2.delete();
    @(negedge clk); #2 start2 = 1;
    @(negedge clk); #2 start2 = 0;
    to = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (!busy2) begin to = 0; break; end
    end
    repeat (10) @(negedge clk);
    #1;
    vectors++;
    if (to || log2.size() != 4) begin
      miscompares++;
      $display("FAIL wrap count: got %0d (timeout %0d) want 4", log2.size(), to);
    end
    for (int i = 0; i < log2.size() && i < 4; i++) begin
      vectors++;
      if (log2[i] !== rom2[i]) begin
        miscompares++;
        $display("FAIL wrap txn%0d: got %h want %h", i, log2[i], rom2[i]);
      end
    end
    vectors++;
    if ({done2, error2, busy2} !== 3'b100) begin
      miscompares++;
      $display("FAIL wrap status: got done=%b err=%b busy=%b want 1 0 0", done2, error2, busy2);
    end
  endtask

  task automatic test_random();
    bit to; int fg, len;
    for (int it = 0; it < 8; it++) begin
      rom_clear();
      len = $urandom_range(8, 2);
      for (int i = 0; i < len; i++) rom[i] = ($urandom_range(4, 0) == 0) ? DLY_W : rnd_word();
      nack_plan.delete();
      for (int i = 0; i < 40; i++) nack_plan.push_back($urandom_range(3, 0) == 0);
      ready_wait_cfg = -1; lat_lo = 1; lat_hi = 8; stray_en = $urandom_range(1, 0);
      run_seq(4000, -1, 0, to, fg);
      vectors++;
      if (to || act_q.size() != exp_q.size() || proto_err != 0) begin
        miscompares++;
        $display("FAIL random%0d count: got %0d proto=%0d (timeout %0d) want %0d 0",
                 it, act_q.size(), proto_err, to, exp_q.size());
      end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
        vectors++;
        if (act_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL random%0d txn%0d: got %h want %h", it, i, act_q[i], exp_q[i]);
        end
      end
      vectors++;
      if ({done, error, busy} !== {exp_done, exp_err, 1'b0} || (exp_err && err_addr !== exp_err_addr)) begin
        miscompares++;
        $display("FAIL random%0d status: got done=%b err=%b busy=%b ea=%0d want %b %b 0 %0d",
                 it, done, error, busy, err_addr, exp_done, exp_err, exp_err_addr);
      end
    end
  endtask

  initial begin
    reset_n = 0; start = 0; start2 = 0;
    ready_wait_cfg = 0; lat_lo = 1; lat_hi = 1; stray_en = 0;
    rdy_wait = 0; last_evt = 0; proto_err = 0;
    rom_clear();
    for (int i = 0; i < 4; i++) rom2[i] = 16'h0000;
    test_reset();
    test_delay_seq();
    test_nack_retry();
    test_error();
    test_ready_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ov7670_cfg_seq.md
Name: ov7670_cfg_seq

Overview:
- Sequences the OV7670 power-up register configuration over SCCB.
- Walks an external register/value ROM and issues one 16-bit write per entry ({reg[7:0], val[7:0]}) to the SCCB master.
- Handles inline delay entries, retries NACKed writes and reports done/error to the capture pipeline.
- Sits between the system start/reset logic and the SCCB master that drives i2c_scl/i2c_sda; the final entry (e.g. 0x13E5) arms camera streaming.

Parameters:
- ADDR_W, 8, ROM address width; max 2^ADDR_W entries.
- DELAY_CYCLES, 1000000, clk cycles waited for a delay entry (10 ms at 100 MHz).
- MAX_RETRY, 3, re-issues allowed per entry after NACK before error.
- END_WORD, 16'hFFFF, ROM word terminating the sequence.
- DELAY_WORD, 16'hFFF0, ROM word inserting a DELAY_CYCLES wait.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins sequence from address 0.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  16  ROM word; valid exactly 1 cycle after rom_addr changes.
- cmd_valid  out  1  write request to SCCB master.
- cmd_ready  in  1  SCCB master accepts cmd when cmd_valid&cmd_ready.
- cmd_data  out  16  {reg, val} for current write.
- xfer_done  in  1  single-cycle pulse; SCCB transaction finished.
- xfer_nack  in  1  qualified by xfer_done; 1 = slave NACK.
- busy  out  1  sequence in progress.
- done  out  1  sticky; sequence completed cleanly.
- error  out  1  sticky; retries exhausted.
- err_addr  out  ADDR_W  ROM address of failing entry.

Behaviour:
- Reset (async, reset_n=0): state IDLE; rom_addr=0, cmd_valid=0, cmd_data=0, busy=0, done=0, error=0, err_addr=0, retry and delay counters 0. Reset mid-transfer aborts immediately; no cmd_valid after deassert until the next start.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_XFER, DELAY, NEXT, DONE, ERROR.
- IDLE: start -> FETCH; rom_addr=0, busy=1, done=0, error=0.
- FETCH: one cycle for ROM latency -> DECODE.
- DECODE, on rom_data:
  - == END_WORD -> DONE.
  - == DELAY_WORD -> DELAY; counter loaded with DELAY_CYCLES-1.
  - else -> ISSUE; latch cmd_data=rom_data, retry=0.
- ISSUE: cmd_valid=1; cmd_data held stable until accepted; on cmd_valid&cmd_ready -> WAIT_XFER, cmd_valid=0 the next cycle.
- WAIT_XFER: wait for xfer_done.
  - xfer_nack=0 -> NEXT.
  - xfer_nack=1 and retry<MAX_RETRY -> retry+1, ISSUE (same cmd_data).
  - Otherwise -> ERROR; err_addr=rom_addr.
  - xfer_done arriving in the same cycle as acceptance is ignored; only pulses in WAIT_XFER count.
- DELAY: counter decrements each cycle; at 0 -> NEXT. Exactly DELAY_CYCLES cycles spent in DELAY.
- NEXT:
  - rom_addr == 2^ADDR_W-1 (no terminator) -> DONE.
  - else rom_addr+1 -> FETCH.
- DONE: busy=0, done=1 -> IDLE next cycle; done stays high until next start or reset.
- ERROR: busy=0, error=1, cmd_valid=0 -> IDLE next cycle; error/err_addr sticky until next start or reset.
- start while busy=1 is ignored. start in the same cycle DONE/ERROR returns to IDLE is ignored.
- Minimum latency start -> first cmd_valid: 3 cycles (FETCH, DECODE, ISSUE).
- Counter widths: retry counter clog2(MAX_RETRY+1); delay counter clog2(DELAY_CYCLES+1).

Test Plan:
- ROM {1280, FFF0, 13E5, FFFF}, DELAY_CYCLES=20, cmd_ready=1, xfer_done 10 cycles after accept, nack=0 -> cmd_data 1280 then 13E5; gap includes exactly 20 DELAY cycles; done=1, error=0, busy falls after entry 3.
- Entry 0x3A04, first xfer_nack=1 then 0 -> cmd_data 3A04 issued twice; done=1, error=0.
- Entry at addr 5, MAX_RETRY=3, all NACK -> 4 issues of the same word; error=1, err_addr=5, done=0, no further cmd_valid.
- cmd_ready held low 50 cycles -> cmd_valid and cmd_data stable throughout; accepted on the first ready cycle; single WAIT_XFER.
- Second start pulse while busy -> ignored; exactly one pass through the ROM.
- reset_n low during WAIT_XFER -> all outputs return to reset values asynchronously; new start after release restarts at rom_addr=0.
- ADDR_W=2, ROM with no END_WORD -> 4 writes issued, then done=1.
